// File: rtl/avst_pkt_gen.sv
// Avalon-ST packet generator: emits num_pkts framed packets of len bytes where
// byte k of packet p is (seed + p + k) mod 256, first byte in the top lane.
//
// Handshake: a word transfers on any cycle with src_vld_o & src_rdy_i. While
// src_vld_o is high and src_rdy_i is low, data/empty/sop/eop hold and vld stays up.
module avst_pkt_gen #(
    parameter int MAX_LEN    = 2048,
    parameter int IPG        = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             cfg_start_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]                     cfg_len_i,
    input  logic [15:0]                                      cfg_num_pkts_i,
    input  logic [7:0]                                       cfg_seed_i,
    output logic [DATA_WIDTH-1:0]                            src_data_o,
    output logic [(DATA_WIDTH > 8 ? $clog2(DATA_WIDTH/8) : 1)-1:0] src_empty_o,
    output logic                                             src_sop_o,
    output logic                                             src_eop_o,
    output logic                                             src_vld_o,
    input  logic                                             src_rdy_i,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic [15:0]                                      pkt_cnt_o,
    output logic [1:0]                                       state_o
);

    localparam int BPW     = DATA_WIDTH / 8;
    localparam int SHIFT   = $clog2(BPW);
    localparam int EMPTY_W = (BPW > 1) ? SHIFT : 1;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int WCNT_W  = $clog2(MAX_LEN / BPW + 1);
    localparam int KW      = LEN_W + SHIFT + 1;
    localparam int GAP_W   = (IPG > 1) ? $clog2(IPG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [15:0]         num_q, num_d;
    logic [7:0]          seed_q, seed_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic [WCNT_W-1:0]   word_q, word_d;
    logic                nil_q, nil_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic                vld, sop, eop, done, last_word;
    logic [LEN_W:0]      len_up;
    logic [LEN_W-1:0]    neg_len;
    logic [KW-1:0]       base, k;
    logic [DATA_WIDTH-1:0] data_w;

    assign len_up    = {1'b0, cfg_len_i} + (LEN_W+1)'(BPW - 1);
    assign last_word = (word_q == words_q - WCNT_W'(1));
    assign neg_len   = '0 - len_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        num_d     = num_q;
        seed_d    = seed_q;
        words_d   = words_q;
        word_d    = word_q;
        nil_d     = nil_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        vld       = 1'b0;
        sop       = 1'b0;
        eop       = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    len_d   = cfg_len_i;
                    num_d   = cfg_num_pkts_i;
                    seed_d  = cfg_seed_i;
                    words_d = WCNT_W'(len_up >> SHIFT);
                    nil_d   = (cfg_len_i == '0) || (cfg_num_pkts_i == 16'd0);
                    cnt_d   = 16'd0;
                    word_d  = '0;
                    gap_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // An empty job spends one silent cycle here so done lands two cycles after start.
                if (nil_q) begin
                    state_d = FIN;
                end else begin
                    vld = 1'b1;
                    sop = (word_q == '0);
                    eop = last_word;
                    if (src_rdy_i) begin
                        if (last_word) begin
                            word_d = '0;
                            cnt_d  = cnt_q + 16'd1;
                            if (cnt_q + 16'd1 == num_q) begin
                                state_d = FIN;
                            end else if (IPG > 0) begin
                                gap_d   = '0;
                                state_d = GAP;
                            end
                        end else begin
                            word_d = word_q + WCNT_W'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(IPG - 1)) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lanes past len on the eop word, and every lane while vld is low, read as zero.
    always_comb begin
        data_w = '0;
        k      = '0;
        base   = KW'(word_q) << SHIFT;
        for (int l = 0; l < BPW; l++) begin
            k = base + KW'(l);
            if (vld && (k < KW'(len_q))) begin
                data_w[DATA_WIDTH-1-8*l -: 8] = seed_q + cnt_q[7:0] + k[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            num_q   <= 16'd0;
            seed_q  <= 8'd0;
            words_q <= '0;
            word_q  <= '0;
            nil_q   <= 1'b0;
            cnt_q   <= 16'd0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            seed_q  <= seed_d;
            words_q <= words_d;
            word_q  <= word_d;
            nil_q   <= nil_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign src_data_o  = data_w;
    assign src_empty_o = (vld && eop) ? neg_len[EMPTY_W-1:0] : '0;
    assign src_sop_o   = sop;
    assign src_eop_o   = eop;
    assign src_vld_o   = vld;
    assign busy_o      = (state_q == SEND) || (state_q == GAP);
    assign done_o      = done;
    assign pkt_cnt_o   = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_avst_pkt_gen.sv
// Bench for avst_pkt_gen: two instances (IPG=0 and IPG=3) share stimulus and are
// checked every cycle against a queue of expected words built from the byte rule.
module tb_avst_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] len = '0;
  logic [15:0] num = '0;
  logic [7:0]  seed = '0;
  logic        rdy = 1'b1;

  logic [31:0] data[2];
  logic [1:0]  empty[2];
  logic        sop[2], eop[2], vld[2], busy[2], done[2];
  logic [15:0] pcnt[2];
  logic [1:0]  st[2];

  avst_pkt_gen #(.MAX_LEN(2048), .IPG(0), .DATA_WIDTH(32)) u_ipg0 (
    .clk(clk), .rst(rst), .cfg_start_i(start), .cfg_len_i(len),
    .cfg_num_pkts_i(num), .cfg_seed_i(seed),
    .src_data_o(data[0]), .src_empty_o(empty[0]), .src_sop_o(sop[0]),
    .src_eop_o(eop[0]), .src_vld_o(vld[0]), .src_rdy_i(rdy),
    .busy_o(busy[0]), .done_o(done[0]), .pkt_cnt_o(pcnt[0]), .state_o(st[0])
  );

  avst_pkt_gen #(.MAX_LEN(2048), .IPG(3), .DATA_WIDTH(32)) u_ipg3 (
    .clk(clk), .rst(rst), .cfg_start_i(start), .cfg_len_i(len),
    .cfg_num_pkts_i(num), .cfg_seed_i(seed),
    .src_data_o(data[1]), .src_empty_o(empty[1]), .src_sop_o(sop[1]),
    .src_eop_o(eop[1]), .src_vld_o(vld[1]), .src_rdy_i(rdy),
    .busy_o(busy[1]), .done_o(done[1]), .pkt_cnt_o(pcnt[1]), .state_o(st[1])
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: each entry is {sop, eop, empty[1:0], data[31:0]}
  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int idx[2], mcnt[2], hold_cnt[2], start_cyc[2], last_xfer[2], gap_cnt[2];
  bit in_job[2], pend_gap[2];
  int job_num = 0;
  bit job_nil = 1'b0;
  int rdy_mode = 0;
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ipg_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Expected word stream straight from the byte rule.
  function automatic void build(input int l, input int n, input int s);
    int w;
    logic [31:0] word;
    logic [1:0]  emp;
    exp_q.delete();
    w = (l + 3) / 4;
    if (l == 0 || n == 0) return;
    for (int p = 0; p < n; p++) begin
      for (int wi = 0; wi < w; wi++) begin
        word = '0;
        for (int lane = 0; lane < 4; lane++) begin
          int kk;
          kk = wi * 4 + lane;
          if (kk < l) word[31-8*lane -: 8] = 8'((s + p + kk) % 256);
        end
        emp = (wi == w - 1) ? 2'(w * 4 - l) : 2'd0;
        exp_q.push_back({(wi == 0), (wi == w - 1), emp, word});
      end
    end
  endfunction

  // rdy driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          int off;
          off = cyc - start_cyc[0] - 1;
          rdy = (off >= 0 && off < 6) ? pat[off] : 1'b1;
        end
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        in_job[d] = 1'b0; idx[d] = 0; mcnt[d] = 0; hold_cnt[d] = 0; pend_gap[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (start && !in_job[d]) begin
          in_job[d] = 1'b1; start_cyc[d] = cyc; idx[d] = 0; mcnt[d] = 0;
          pend_gap[d] = 1'b0; gap_cnt[d] = 0; last_xfer[d] = cyc;
        end
        if (!in_job[d] || cyc == start_cyc[d]) begin
          check($sformatf("idle_vld%0d", d), 64'(vld[d]), 64'd0);
          check($sformatf("idle_busy%0d", d), 64'(busy[d]), 64'd0);
          check($sformatf("idle_done%0d", d), 64'(done[d]), 64'd0);
          check($sformatf("idle_pkt_cnt%0d", d), 64'(pcnt[d]), 64'(hold_cnt[d]));
        end else begin
          bit exp_done, exp_vld;
          exp_done = job_nil ? (cyc == start_cyc[d] + 2)
                             : (idx[d] == exp_q.size() && cyc == last_xfer[d] + 1);
          exp_vld  = !job_nil && idx[d] < exp_q.size() &&
                     (!pend_gap[d] || gap_cnt[d] == ipg_of(d));
          check($sformatf("done%0d", d), 64'(done[d]), 64'(exp_done));
          check($sformatf("busy%0d", d), 64'(busy[d]), 64'(!exp_done));
          check($sformatf("pkt_cnt%0d", d), 64'(pcnt[d]), 64'(mcnt[d]));
          check($sformatf("vld%0d", d), 64'(vld[d]), 64'(exp_vld));
          if (pend_gap[d]) begin
            if (vld[d]) pend_gap[d] = 1'b0;
            else gap_cnt[d]++;
          end
          if (vld[d]) begin
            if (idx[d] < exp_q.size())
              check($sformatf("word%0d_%0d", d, idx[d]),
                    64'({sop[d], eop[d], empty[d], data[d]}), 64'(exp_q[idx[d]]));
            else
              check($sformatf("extra_xfer%0d", d), 64'(vld[d]), 64'd0);
            if (rdy) begin
              idx[d]++;
              last_xfer[d] = cyc;
              if (eop[d]) begin
                mcnt[d]++;
                if (mcnt[d] < job_num) begin
                  pend_gap[d] = 1'b1; gap_cnt[d] = 0;
                end
              end
            end
          end
          if (exp_done) begin
            in_job[d] = 1'b0;
            hold_cnt[d] = mcnt[d];
          end
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input int l, input int n, input int s);
    @(posedge clk); #1;
    len = 12'(l); num = 16'(n); seed = 8'(s); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int l, input int n, input int s, input int mode);
    bit fin;
    build(l, n, s);
    job_num = n;
    job_nil = (l == 0 || n == 0);
    rdy_mode = mode;
    pulse_start(l, n, s);
    fin = 1'b0;
    for (int t = 0; t < 5000 && !fin; t++) begin
      @(negedge clk); #1;
      if (!in_job[0] && !in_job[1]) fin = 1'b1;
    end
    check("job_timeout", 64'(fin), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_vld%0d", tag, d), 64'(vld[d]), 64'd0);
      check($sformatf("%s_busy%0d", tag, d), 64'(busy[d]), 64'd0);
      check($sformatf("%s_pkt_cnt%0d", tag, d), 64'(pcnt[d]), 64'd0);
      check($sformatf("%s_outs%0d", tag, d),
            64'({sop[d], eop[d], empty[d], data[d], done[d], st[d]}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // hand-computed words pin the model
    build(5, 1, 8'h10);
    check("pin_len5_w0", 64'(exp_q[0]), 64'({1'b1, 1'b0, 2'd0, 32'h10111213}));
    check("pin_len5_w1", 64'(exp_q[1]), 64'({1'b0, 1'b1, 2'd3, 32'h14000000}));
    build(4, 3, 8'hFE);
    check("pin_fe_size", 64'(exp_q.size()), 64'd3);
    check("pin_fe_w0", 64'(exp_q[0]), 64'({1'b1, 1'b1, 2'd0, 32'hFEFF0001}));
    check("pin_fe_w1", 64'(exp_q[1]), 64'({1'b1, 1'b1, 2'd0, 32'hFF000102}));
    check("pin_fe_w2", 64'(exp_q[2]), 64'({1'b1, 1'b1, 2'd0, 32'h00010203}));

    run_job(5, 1, 8'h10, 0);
    run_job(4, 3, 8'hFE, 0);
    run_job(8, 2, 8'h33, 0);
    run_job(12, 1, 8'h5A, 2);
    run_job(0, 5, 8'h07, 0);
    run_job(6, 0, 8'h09, 0);
    run_job(1, 2, 8'hFF, 1);
    for (int i = 0; i < 12; i++)
      run_job($urandom_range(0, 40), $urandom_range(0, 4), $urandom_range(0, 255), 1);

    // reset mid-packet, with an ignored start while busy
    build(16, 3, 8'h80);
    job_num = 3; job_nil = 1'b0; rdy_mode = 0;
    pulse_start(16, 3, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    len = 12'd2; num = 16'd1; seed = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_job(16, 1, 8'h80, 0);
    run_job(9, 2, 8'h42, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avst_pkt_gen.md
Name: avst_pkt_gen

Overview:
- Avalon-ST packet transmitter: generates framed packets (sop/eop/empty) with a deterministic byte pattern.
- Drives the master side of an avalon_st_if, typically into a fifo write port.
- Serves as traffic source for store-and-forward and back-pressure testing, and as a production test-pattern source.
- Software-style config is captured on a start pulse. Completion is flagged with a done pulse and a packet counter.

Parameters:
- MAX_LEN, 2048: maximum packet length in bytes; sizes cfg_len.
- IPG, 0: idle cycles forced with vld low between an eop transfer and the next sop; 0 means back-to-back.
- Derived, not overridable: DATA_WIDTH = src.DATA_WIDTH (multiple of 8); BPW = DATA_WIDTH/8 (power of 2); EMPTY_W = $clog2(BPW).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  single-cycle start request.
- cfg_len  in  $clog2(MAX_LEN+1)  packet length in bytes, 0..MAX_LEN.
- cfg_num_pkts  in  16  number of packets to send.
- cfg_seed  in  8  first byte value of packet 0.
- src  avalon_st_if.master  -  data, empty, sop, eop, vld out; rdy in.
- busy  out  1  high from accepted start until after the last transfer.
- done  out  1  one-cycle pulse at job end.
- pkt_cnt  out  16  packets fully sent (eop transferred) in the current job.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; src.vld=0, src.sop=0, src.eop=0, src.empty=0, src.data=0; busy=0, done=0, pkt_cnt=0.
- Reset mid-packet: the packet is abandoned with no eop. Downstream is reset together with this block.
- Transfer definition: a transfer occurs on a cycle with src.vld & src.rdy.
- While src.vld=1 and src.rdy=0, data/empty/sop/eop are held stable and vld is not dropped.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - cfg_start=1 captures cfg_len, cfg_num_pkts and cfg_seed into internal registers; pkt_cnt clears to 0; busy rises next cycle.
  - If captured len=0 or num_pkts=0: go to FIN with no transfers.
  - Otherwise go to SEND; src.vld=1 with sop=1 on the cycle after start (1-cycle latency).
- cfg_start while busy=1 is ignored. Config inputs are only sampled in IDLE.
- SEND:
  - Words per packet W = ceil(len/BPW).
  - Byte k of packet p = (seed + p + k) mod 256.
  - Byte lane 0 (first byte) is data[DATA_WIDTH-1 -: 8]; lanes descend toward LSB.
  - sop=1 on word 0 only; eop=1 on word W-1 only; both set when W=1.
  - empty = W*BPW - len on the eop word, 0 otherwise. Unused lanes on the eop word are driven 0.
  - Word index advances only on a transfer.
  - On the eop transfer, pkt_cnt increments the same cycle (visible next cycle).
  - After eop transfer, if more packets remain: go to GAP if IPG>0, else stay in SEND with the next word's sop=1 the following cycle (no bubble).
  - After the eop transfer of the last packet: go to FIN.
- GAP: vld=0 for exactly IPG cycles, then SEND.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
  - pkt_cnt holds its value until the next accepted start.
  - Back-to-back jobs: a start is accepted in the IDLE cycle immediately following FIN.
- Arithmetic:
  - Byte pattern wraps mod 256.
  - pkt_cnt wraps mod 2^16; num_pkts is at most 65535, so no wrap within a job.
  - Word counter width is $clog2(MAX_LEN/BPW+1).
- Back-pressure: rdy may toggle arbitrarily; output content depends only on transfer count, never on stall pattern.

Test Plan (DATA_WIDTH=32, BPW=4):
- len=5, num=1, seed=0x10, rdy=1, IPG=0:
  - Word 1: data=0x10111213, sop=1, eop=0, empty=0.
  - Word 2: data=0x14000000, sop=0, eop=1, empty=3.
  - done pulses 1 cycle after word 2; pkt_cnt=1.
- len=4, num=3, seed=0xFE, IPG=0, rdy=1:
  - Three consecutive single-word packets with sop=eop=1, empty=0, no vld gap.
  - Data: 0xFEFF0001, 0xFF000102, 0x00010203.
  - pkt_cnt = 1, 2, 3.
- len=8, num=2, IPG=3: exactly 3 cycles of vld=0 between the first eop transfer and the second sop.
- rdy pattern 1,0,0,1,0,1 during len=12: each word is held stable through stalls; sequence is identical to the rdy=1 run; empty=0 on eop.
- len=0, num=5 and len=6, num=0: no vld ever; done pulses on the second cycle after start; pkt_cnt=0.
- Assert rst mid-packet (after word 1 of len=16):
  - vld drops asynchronously; busy=0, pkt_cnt=0.
  - After release, a new start produces a fresh packet from seed.
  - cfg_start asserted while busy is ignored.
